// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with a 3-state handshake FSM.
// Define ALU_ARB_FIXED_PRIO_EN to make req0 always win contention (default: round-robin).
module alu_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic [3:0]   req0_opcode_i,
    input  logic [N-1:0] req0_a_i,
    input  logic [N-1:0] req0_b_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic [3:0]   req1_opcode_i,
    input  logic [N-1:0] req1_a_i,
    input  logic [N-1:0] req1_b_i,
    output logic [3:0]   alu_opcode_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    input  logic [N-1:0] alu_result_i,
    input  logic         alu_c_i,
    input  logic         alu_z_i,
    input  logic         alu_n_i,
    input  logic         alu_v_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic [N-1:0] rsp_result_o,
    output logic         rsp_c_o,
    output logic         rsp_z_o,
    output logic         rsp_n_o,
    output logic         rsp_v_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t       r_state;
    logic [3:0]   r_op;
    logic [N-1:0] r_a, r_b;
    logic         r_id;
    logic         w_pick1, w_idle, w_grant;
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_pick1 = req1_valid_i & ~req0_valid_i;
`else
    // r_last = 1 means req1 was granted last, so req0 wins the next contention
    logic r_last;
    assign w_pick1 = req1_valid_i & (~req0_valid_i | ~r_last);
`endif
    assign w_idle       = r_state == IDLE;
    assign req0_ready_o = w_idle & req0_valid_i & ~w_pick1;
    assign req1_ready_o = w_idle & w_pick1;
    assign w_grant      = req0_ready_o | req1_ready_o;
    assign alu_opcode_o = r_op;
    assign alu_a_o      = r_a;
    assign alu_b_o      = r_b;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last       <= 1'b1;
`endif
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
            rsp_result_o <= '0;
            rsp_c_o      <= 1'b0;
            rsp_z_o      <= 1'b0;
            rsp_n_o      <= 1'b0;
            rsp_v_o      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_grant) begin
                    r_op    <= w_pick1 ? req1_opcode_i : req0_opcode_i;
                    r_a     <= w_pick1 ? req1_a_i : req0_a_i;
                    r_b     <= w_pick1 ? req1_b_i : req0_b_i;
                    r_id    <= w_pick1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    r_last  <= w_pick1;
`endif
                    r_state <= EXEC;
                end
                EXEC: begin
                    rsp_valid_o  <= 1'b1;
                    rsp_id_o     <= r_id;
                    rsp_result_o <= alu_result_i;
                    rsp_c_o      <= alu_c_i;
                    rsp_z_o      <= alu_z_i;
                    rsp_n_o      <= alu_n_i;
                    rsp_v_o      <= alu_v_i;
                    r_state      <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 4, operand/result width in bits; SHALL match the N of the shared alu instance.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 reqK_valid_i, K=0,1  input  1  requester K has an operation pending.
REQ-005 reqK_ready_o, K=0,1  output  1  requester K's operation accepted this cycle.
REQ-006 reqK_opcode_i  input  4  ALU opcode from requester K.
REQ-007 reqK_a_i, reqK_b_i  input  N  operands from requester K.
REQ-008 alu_opcode_o  output  4  opcode driven to the shared alu.
REQ-009 alu_a_o, alu_b_o  output  N  operands driven to the alu.
REQ-010 alu_result_i  input  N  combinational alu result.
REQ-011 alu_c_i, alu_z_i, alu_n_i, alu_v_i  input  1  combinational alu flags.
REQ-012 rsp_valid_o  output  1  response registers hold a completed operation.
REQ-013 rsp_ready_i  input  1  consumer accepts the response.
REQ-014 rsp_id_o  output  1  requester index the response belongs to.
REQ-015 rsp_result_o  output  N  registered result.
REQ-016 rsp_c_o, rsp_z_o, rsp_n_o, rsp_v_o  output  1  registered flags.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP.
REQ-018 IDLE: if any reqK_valid_i, SHALL grant one requester, assert its reqK_ready_o combinationally that cycle, latch its opcode/a/b and id, go to EXEC; else stay in IDLE.
REQ-019 reqK_ready_o SHALL be 0 in EXEC and RESP, and at most one ready SHALL be high per cycle.
REQ-020 Contention (both valid in IDLE): grant the requester not granted last; last-grant register updates on every grant.
REQ-021 alu_opcode_o/alu_a_o/alu_b_o SHALL always drive the latched operands, so they stay stable across all states.
REQ-022 EXEC: lasts exactly one cycle; at its end SHALL capture alu_result_i and the four flags into the response registers, go to RESP.
REQ-023 RESP: rsp_valid_o=1; response registers SHALL hold stable until rsp_ready_i=1, then go to IDLE next cycle.
REQ-024 rsp_valid_o SHALL be 0 in IDLE and EXEC; latency from accept to rsp_valid_o is 2 cycles; minimum 3 cycles per operation.
REQ-025 Requests arriving during EXEC/RESP SHALL wait; requesters SHALL hold valid and payload stable until ready.
REQ-026 rsp_ready_i high before RESP SHALL have no effect.

Reset
REQ-027 rst_ni low SHALL force IDLE, last grant = 1 (req0 wins first contention), latched opcode/operands = 0, rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, all rsp flags 0.
REQ-028 Reset mid-operation SHALL discard the in-flight operation; no response is produced for it.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN: defined, req0 SHALL always win contention and the last-grant register is not used; undefined, round-robin per REQ-020.

Verification
REQ-030 N=4, req0 only, opcode 0110, a=0111, b=0001 -> ready0 1 cycle, 2 cycles later rsp_valid_o=1, id=0, result=1000, n=1, v=1, c=0, z=0.
REQ-031 req1 only, opcode 0110, a=1111, b=0001 -> rsp id=1, result=0000, c=1, z=1, n=0, v=0.
REQ-032 Both valid continuously for 4 ops, macro undefined -> grant order 0,1,0,1; macro defined -> 0,0,0,0.
REQ-033 rsp_ready_i low 5 cycles in RESP -> rsp_valid_o and rsp payload constant; no ready to either requester until 1 cycle after rsp_ready_i.
REQ-034 rst_ni low during EXEC -> next cycle IDLE, rsp_valid_o=0, all rsp outputs 0, no response emitted.
